// File: rtl/universal_shift_reg.sv
// Universal shift register with parallel load, shifts, rotates and an
// automatic LSB-first serialiser sequenced by a small IDLE/SHIFT/DONE FSM.
module universal_shift_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam int CW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

    // Last counter value seen in SHIFT; the shift taken from here ends the serialise.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             busy_r;
    logic             done_r;

    // Next-state, next-data and counter decode; everything holds when enable is low.
    always_comb begin
        q_nxt_s     = q_r;
        cnt_nxt_s   = cnt_r;
        state_nxt_s = state_r;
        if (enable) begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        q_nxt_s     = d;
                        cnt_nxt_s   = {CW{1'b0}};
                        state_nxt_s = ST_SHIFT;
                    end else begin
                        case (mode)
                            3'b000:  q_nxt_s = q_r;
                            3'b001:  q_nxt_s = d;
                            3'b010:  q_nxt_s = {sin_l, q_r[WIDTH-1:1]};
                            3'b011:  q_nxt_s = {q_r[WIDTH-2:0], sin_r};
                            3'b100:  q_nxt_s = {q_r[0], q_r[WIDTH-1:1]};
                            3'b101:  q_nxt_s = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                            3'b110:  q_nxt_s = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
                            3'b111:  q_nxt_s = {WIDTH{1'b0}};
                            default: q_nxt_s = q_r;
                        endcase
                    end
                end
                ST_SHIFT: begin
                    q_nxt_s   = {sin_l, q_r[WIDTH-1:1]};
                    cnt_nxt_s = cnt_r + CW'(1'b1);
                    if (cnt_r == CNT_LAST) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State registers; busy/done are registered copies of the next state decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r     <= RESET_VAL;
            cnt_r   <= {CW{1'b0}};
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            q_r     <= q_nxt_s;
            cnt_r   <= cnt_nxt_s;
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s == ST_SHIFT);
            done_r  <= (state_nxt_s == ST_DONE);
        end
    end

    assign q      = q_r;
    assign sout_r = q_r[0];
    assign sout_l = q_r[WIDTH-1];
    assign busy   = busy_r;
    assign done   = done_r;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed checks of every mode,
// the serialiser (stall, async reset, ignored start) plus a random phase, all
// compared against a behavioural model.
module tb_universal_shift_reg;

    localparam int           W  = 8;
    localparam logic [W-1:0] RV = 8'h5A;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [2:0]   mode = 3'b000;
    logic [W-1:0] d = '0;
    logic         sin_l = 1'b0;
    logic         sin_r = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] q;
    logic         sout_r, sout_l, busy, done;

    int errors = 0;
    int checks = 0;

    // Behavioural model: register value, shifts still owed, done flag.
    logic [W-1:0] m_q = RV;
    int           m_rem = 0;
    bit           m_done = 1'b0;

    universal_shift_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .d(d),
        .sin_l(sin_l), .sin_r(sin_r), .start(start), .q(q),
        .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q"}, 32'(q), 32'(m_q));
        chk({tag, ".busy"}, 32'(busy), 32'(m_rem > 0));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".sout_r"}, 32'(sout_r), 32'(m_q[0]));
        chk({tag, ".sout_l"}, 32'(sout_l), 32'(m_q[W-1]));
        chk({tag, ".excl"}, 32'(busy & done), 32'(0));
        if (m_rem > 0) chk({tag, ".cnt"}, 32'(dut.cnt_r), 32'(W - 1 - m_rem));
    endtask

    task automatic model_edge(input bit en, input logic [2:0] md, input logic [W-1:0] dd,
                              input bit sl, input bit sr, input bit st);
        if (!en) return;
        if (m_done) begin
            m_done = 1'b0;
        end else if (m_rem > 0) begin
            m_q = (m_q >> 1) | (W'(sl) << (W - 1));
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (st) begin
            m_q = dd;
            m_rem = W - 1;
        end else begin
            case (md)
                3'd1: m_q = dd;
                3'd2: m_q = (m_q >> 1) | (W'(sl) << (W - 1));
                3'd3: m_q = (m_q << 1) | W'(sr);
                3'd4: m_q = (m_q >> 1) | (W'(m_q[0]) << (W - 1));
                3'd5: m_q = (m_q << 1) | W'(m_q[W-1]);
                3'd6: m_q = W'($signed(m_q) >>> 1);
                3'd7: m_q = '0;
                default: ;
            endcase
        end
    endtask

    task automatic step(input string tag, input bit en, input logic [2:0] md,
                        input logic [W-1:0] dd, input bit sl, input bit sr, input bit st);
        enable = en; mode = md; d = dd; sin_l = sl; sin_r = sr; start = st;
        model_edge(en, md, dd, sl, sr, st);
        @(posedge clk); #1;
        chk_all(tag);
    endtask

    // Full serialise of dv; optional 3-cycle stall before sample stall_at;
    // start is pulsed randomly while busy and must be ignored.
    task automatic serial(input string tag, input logic [W-1:0] dv, input int stall_at);
        logic [W-1:0] seq;
        logic [W-1:0] qf;
        logic [31:0]  cf;
        int nb, nd, idx;
        seq = '0; nb = 0; nd = 0; idx = 0;
        step({tag, ".load"}, 1'b1, 3'b011, dv, 1'($urandom), 1'($urandom), 1'b1);
        chk({tag, ".loadq"}, 32'(q), 32'(dv));
        for (int k = 0; k < 12; k++) begin
            if (busy || done) begin
                if (idx < W) seq[idx] = sout_r;
                idx++;
            end
            nb += int'(busy);
            nd += int'(done);
            if (k == stall_at) begin
                qf = q; cf = 32'(dut.cnt_r);
                for (int s = 0; s < 3; s++) begin
                    step({tag, ".stall"}, 1'b0, 3'($urandom), W'($urandom),
                         1'($urandom), 1'($urandom), 1'($urandom));
                    chk({tag, ".frzq"}, 32'(q), 32'(qf));
                    chk({tag, ".frzcnt"}, 32'(dut.cnt_r), cf);
                    chk({tag, ".frzbusy"}, 32'(busy), 32'(1));
                end
            end
            step({tag, ".run"}, 1'b1, 3'($urandom), W'($urandom), 1'($urandom),
                 1'($urandom), (m_rem > 0) ? 1'($urandom) : 1'b0);
        end
        chk({tag, ".order"}, 32'(seq), 32'(dv));
        chk({tag, ".nbits"}, 32'(idx), 32'(W));
        chk({tag, ".busycyc"}, 32'(nb), 32'(W - 1));
        chk({tag, ".donecyc"}, 32'(nd), 32'(1));
    endtask

    logic [2:0]   op_mode [5] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    logic [W-1:0] op_exp  [5] = '{8'hD2, 8'h4A, 8'hD2, 8'h4B, 8'hD2};
    bit           op_sl   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit           op_sr   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset held across edges with enable and start active.
        enable = 1'b1; start = 1'b1; mode = 3'b001; d = 8'hFF;
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst.q", 32'(q), 32'(RV));
            chk("rst.busy", 32'(busy), 32'(0));
            chk("rst.done", 32'(done), 32'(0));
        end
        @(negedge clk); rst_n = 1'b1;
        step("first", 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0);
        chk("first.q", 32'(q), 32'(8'hA5));

        // One cycle of each shift/rotate mode from A5.
        for (int i = 0; i < 5; i++) begin
            step("ld", 1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 1'b0);
            step("op", 1'b1, op_mode[i], 8'h00, op_sl[i], op_sr[i], 1'b0);
            chk("op.const", 32'(q), 32'(op_exp[i]));
        end
        step("ld81", 1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 1'b0);
        step("asr81", 1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("asr81.const", 32'(q), 32'(8'hC0));
        step("clr", 1'b1, 3'b111, 8'hFF, 1'b1, 1'b1, 1'b0);
        chk("clr.const", 32'(q), 32'(8'h00));
        step("hold", 1'b1, 3'b000, 8'h33, 1'b1, 1'b1, 1'b0);
        step("dis", 1'b0, 3'b001, 8'h33, 1'b1, 1'b1, 1'b1);

        // Serialiser: plain, with a mid-run stall, and another pattern.
        serial("ser96", 8'h96, -1);
        serial("serstall", 8'h96, 3);
        serial("ser3c", 8'h3C, 5);

        // Async reset between edges during SHIFT.
        step("arst.load", 1'b1, 3'b000, 8'hC3, 1'b0, 1'b0, 1'b1);
        step("arst.sh", 1'b1, 3'b000, 8'h00, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        m_q = RV; m_rem = 0; m_done = 1'b0;
        chk("arst.q", 32'(q), 32'(RV));
        chk("arst.busy", 32'(busy), 32'(0));
        chk("arst.done", 32'(done), 32'(0));
        @(posedge clk); #1;
        chk_all("arst.held");
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step("arst.post", 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0);
        step("arst.first", 1'b1, 3'b001, 8'h69, 1'b0, 1'b0, 1'b0);

        // Random phase against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(9, 0) != 0), 3'($urandom), W'($urandom),
                 1'($urandom), 1'($urandom), ($urandom_range(9, 0) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
